cross_road_vehicle_detector: RTL
================================

Name: cross_road_vehicle_detector

Overview:
- Sensor-side companion to the highway/country traffic light controller.
- Conditions the raw country-road loop detector into clean vehicle arrivals and counts queued vehicles.
- Drives the controller's `sensor` request.
- Watches the controller's 2-bit light state to drain the queue while country has green. Forces release of the request after a maximum green time so the highway is not starved.

Parameters:
- DEBOUNCE_CYC, 4: consecutive stable synced cycles needed to accept a loop level change (>=1).
- CNT_W, 4: queue counter width. Saturates at 2^CNT_W-1.
- PASS_CYC, 8: country-green cycles per departing vehicle (>=1).
- MAX_GREEN, 64: maximum country-green cycles before forced release (>=2).
- TMR_W, 7: width of the debounce, pass and green timers. Must hold MAX_GREEN-1, PASS_CYC-1 and DEBOUNCE_CYC.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- loop_raw  input  1  raw loop detector; asynchronous and bouncy; high = vehicle over loop.
- ctrl_state  input  2  controller light state: 00 hwy green/cntry red, 01 both yellow, 10 cntry green/hwy red, 11 illegal (treated as not-green).
- sensor  output  1  vehicle request to the controller; registered.
- queue_cnt  output  CNT_W  vehicles currently waiting or passing.
- max_out  output  1  one-cycle pulse when the max-green limit is hit.
- overflow  output  1  sticky; an arrival was lost at queue saturation.

Behaviour:
- Reset (rst=0, async): sync flops=0, filtered level=0, all timers=0, queue_cnt=0, FSM=IDLE, sensor=0, max_out=0, overflow=0. Reset mid-operation discards the queue with no pulse.
- Synchronizer: 2 flops on loop_raw.
- Debounce:
  - Counter increments while sync2 != filtered; it clears when they are equal.
  - When the counter reaches DEBOUNCE_CYC, filtered takes sync2 and the counter clears.
  - Bounces shorter than DEBOUNCE_CYC cycles are ignored.
- Arrival (arr): single-cycle registered pulse, the cycle after filtered rises. Falling edges produce nothing.
- Departure (dep):
  - Pass timer runs only while ctrl_state==10 and queue_cnt>0. Otherwise it is held at 0.
  - When the timer equals PASS_CYC-1, dep pulses for one cycle and the timer returns to 0.
- Queue update (each edge):
  - arr only: +1. At max, hold and set overflow.
  - dep only: -1.
  - Both: unchanged.
  - dep is never issued at 0.
- Green timer:
  - Counts while ctrl_state==10. It clears on any other value.
  - On reaching MAX_GREEN-1 while FSM=REQ, max_out pulses and the timer holds until ctrl_state leaves 10.
- FSM, registered; sensor=1 only in REQ:
  - IDLE -> REQ when queue_cnt>0.
  - REQ -> IDLE when queue_cnt==0. This has priority over max-out in the same cycle.
  - REQ -> HOLDOFF when the green timer hits MAX_GREEN-1.
  - HOLDOFF -> IDLE when ctrl_state==00. Any remaining queue re-requests on the next cycle via IDLE.
  - Illegal encoding -> IDLE.
- Latency: a clean loop_raw rise held stable gives arr after DEBOUNCE_CYC+3 edges, queue_cnt=1 one edge later, and sensor=1 one edge after that. Total DEBOUNCE_CYC+5 edges (9 with defaults).
- While in HOLDOFF, arrivals still count and departures continue while ctrl_state==10.

Test Plan:
- Reset/idle: rst low for 3 cycles, loop_raw toggling -> all outputs 0. After release with loop_raw=0 for 20 cycles -> sensor=0, queue_cnt=0.
- Single vehicle: loop_raw high for 10 cycles then low, ctrl_state=00 -> queue_cnt=1 and sensor=1 exactly 9 edges after the rise. Drive ctrl_state=10 -> dep after 8 cycles, queue_cnt=0, sensor=0 on the next edge.
- Bounce rejection: loop_raw pulses 3 cycles high / 3 low, repeated 5 times -> queue_cnt stays 0 and sensor stays 0.
- Max-out: queue 5 vehicles, hold ctrl_state=10 with PASS_CYC=16 -> after 64 green cycles max_out pulses once, sensor drops, queue_cnt=2. ctrl_state 01->00 -> sensor reasserts 2 edges after 00.
- Saturation: 16 clean arrivals with ctrl_state=00 -> queue_cnt=15 and overflow=1 sticky; it stays 1 after the queue drains to 0.
- Simultaneous events: arrival aligned with a dep pulse at queue_cnt=3 -> queue_cnt stays 3. Async reset asserted mid-drain -> immediate zeros, then an IDLE restart.

Source files
------------

// File: rtl/cross_road_vehicle_detector.sv
// Country-road loop detector conditioning for the highway/country light controller:
// sync + debounce the loop, count queued vehicles, raise/release the sensor request.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | no request; waits for a queued vehicle
// ST_REQ     | sensor asserted; waits for queue empty or green time limit
// ST_HOLDOFF | request forcibly released; waits for highway green (00)
module cross_road_vehicle_detector #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int CNT_W        = 4,
   parameter int PASS_CYC     = 8,
   parameter int MAX_GREEN    = 64,
   parameter int TMR_W        = 7
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             loop_raw,
   input  logic [1:0]       ctrl_state,
   output logic             sensor,
   output logic [CNT_W-1:0] queue_cnt,
   output logic             max_out,
   output logic             overflow
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_REQ     = 2'b01,
      ST_HOLDOFF = 2'b10
   } state_e;

   localparam logic [TMR_W-1:0] DEB_LAST  = TMR_W'(DEBOUNCE_CYC - 1);
   localparam logic [TMR_W-1:0] PASS_LAST = TMR_W'(PASS_CYC - 1);
   localparam logic [TMR_W-1:0] GRN_LAST  = TMR_W'(MAX_GREEN - 1);
   localparam logic [CNT_W-1:0] Q_MAX     = '1;
   localparam logic [1:0]       CTRL_HWY  = 2'b00;
   localparam logic [1:0]       CTRL_CTRY = 2'b10;

   logic             sync1_q, sync2_q;
   logic             filt_q, filt_d, filt_prev_q;
   logic             arr_q;
   logic [TMR_W-1:0] deb_q, deb_d;
   logic [TMR_W-1:0] pass_q, pass_d;
   logic [TMR_W-1:0] grn_q, grn_d;
   logic [CNT_W-1:0] queue_q, queue_d;
   logic             ovf_q, ovf_d;
   state_e           state_q;
   logic             sensor_q, max_q;

   logic green, q_nz, dep, grn_hit;

   assign green = (ctrl_state == CTRL_CTRY);
   assign q_nz  = (queue_q != '0);

   // A level change is accepted on the cycle the mismatch run reaches DEBOUNCE_CYC.
   always_comb begin
      deb_d  = '0;
      filt_d = filt_q;
      if (sync2_q != filt_q) begin
         if (deb_q == DEB_LAST) begin
            filt_d = sync2_q;
         end else begin
            deb_d = deb_q + TMR_W'(1);
         end
      end
   end

   always_comb begin
      dep    = green && q_nz && (pass_q == PASS_LAST);
      pass_d = '0;
      if (green && q_nz && !dep) begin
         pass_d = pass_q + TMR_W'(1);
      end
   end

   always_comb begin
      grn_d = '0;
      if (green) begin
         grn_d = (grn_q == GRN_LAST) ? grn_q : grn_q + TMR_W'(1);
      end
      grn_hit = green && (grn_d == GRN_LAST);
   end

   // An arrival coinciding with a departure leaves the count untouched, even at saturation.
   always_comb begin
      queue_d = queue_q;
      ovf_d   = ovf_q;
      case ({arr_q, dep})
         2'b10: begin
            if (queue_q == Q_MAX) begin
               ovf_d = 1'b1;
            end else begin
               queue_d = queue_q + CNT_W'(1);
            end
         end
         2'b01:   queue_d = queue_q - CNT_W'(1);
         default: queue_d = queue_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q     <= 1'b0;
         sync2_q     <= 1'b0;
         deb_q       <= '0;
         filt_q      <= 1'b0;
         filt_prev_q <= 1'b0;
         arr_q       <= 1'b0;
         pass_q      <= '0;
         grn_q       <= '0;
         queue_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         sync1_q     <= loop_raw;
         sync2_q     <= sync1_q;
         deb_q       <= deb_d;
         filt_q      <= filt_d;
         filt_prev_q <= filt_q;
         arr_q       <= filt_q & ~filt_prev_q;
         pass_q      <= pass_d;
         grn_q       <= grn_d;
         queue_q     <= queue_d;
         ovf_q       <= ovf_d;
      end
   end

   // Queue-empty release wins over the max-green release in the same cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= ST_IDLE;
         sensor_q <= 1'b0;
         max_q    <= 1'b0;
      end else begin
         sensor_q <= 1'b0;
         max_q    <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (q_nz) begin
                  state_q  <= ST_REQ;
                  sensor_q <= 1'b1;
               end
            end
            ST_REQ: begin
               if (!q_nz) begin
                  state_q <= ST_IDLE;
               end else if (grn_hit) begin
                  state_q <= ST_HOLDOFF;
                  max_q   <= 1'b1;
               end else begin
                  sensor_q <= 1'b1;
               end
            end
            ST_HOLDOFF: begin
               if (ctrl_state == CTRL_HWY) begin
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign sensor    = sensor_q;
   assign queue_cnt = queue_q;
   assign max_out   = max_q;
   assign overflow  = ovf_q;

endmodule
